// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard consumer controller.
// Holds the sequencer state encoding and the special scan-code byte values.
package ps2_kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACK   = 2'd1,
      ST_PARSE = 2'd2
   } kbd_state_e;

   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_BRK     = 8'hF0;
   localparam logic [7:0] SC_ERR0    = 8'h00;
   localparam logic [7:0] SC_ERR1    = 8'hFF;
   localparam logic [7:0] ASCII_NONE = 8'h00;

endpackage

// File: rtl/ps2_kbd_ctrl_scan2ascii.sv
// Set-2 scan code to ASCII lookup: digits and uppercase letters only.
// Anything outside that set reads as ASCII_NONE.
module ps2_scan2ascii
   import ps2_kbd_pkg::*;
(
   input  logic [7:0] scan_code,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = ASCII_NONE;
      case (scan_code)
         8'h45: ascii = 8'h30;
         8'h16: ascii = 8'h31;
         8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;
         8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;
         8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h1C: ascii = 8'h41;
         8'h32: ascii = 8'h42;
         8'h21: ascii = 8'h43;
         8'h23: ascii = 8'h44;
         8'h24: ascii = 8'h45;
         8'h2B: ascii = 8'h46;
         8'h34: ascii = 8'h47;
         8'h33: ascii = 8'h48;
         8'h43: ascii = 8'h49;
         8'h3B: ascii = 8'h4A;
         8'h42: ascii = 8'h4B;
         8'h4B: ascii = 8'h4C;
         8'h3A: ascii = 8'h4D;
         8'h31: ascii = 8'h4E;
         8'h44: ascii = 8'h4F;
         8'h4D: ascii = 8'h50;
         8'h15: ascii = 8'h51;
         8'h2D: ascii = 8'h52;
         8'h1B: ascii = 8'h53;
         8'h2C: ascii = 8'h54;
         8'h3C: ascii = 8'h55;
         8'h2A: ascii = 8'h56;
         8'h1D: ascii = 8'h57;
         8'h22: ascii = 8'h58;
         8'h35: ascii = 8'h59;
         8'h1A: ascii = 8'h5A;
         default: ascii = ASCII_NONE;
      endcase
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Pops scan-code bytes from the ps2_keyboard FIFO, folds E0/F0 prefixes into
// one key event per sequence, and tracks held key, BCD press count and errors.
module ps2_kbd_ctrl
   import ps2_kbd_pkg::*;
#(
   parameter int CNT_DIGITS = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              kbd_data,
   input  logic                    kbd_ready,
   input  logic                    kbd_overflow,
   output logic                    kbd_nextdata_n,
   output logic                    evt_valid,
   output logic [7:0]              evt_code,
   output logic                    evt_ext,
   output logic                    evt_break,
   output logic                    evt_repeat,
   output logic [7:0]              evt_ascii,
   output logic                    key_held,
   output logic [7:0]              held_code,
   output logic [4*CNT_DIGITS-1:0] press_cnt,
   output logic                    err_overflow,
   output logic                    err_kbd
);

   localparam int CW = 4 * CNT_DIGITS;

   kbd_state_e    state_q, state_d;
   logic [7:0]    byte_q, byte_d;
   logic          nextdata_n_q, nextdata_n_d;
   logic          ext_pend_q, ext_pend_d;
   logic          brk_pend_q, brk_pend_d;
   logic          held_q, held_d;
   logic [7:0]    held_code_q, held_code_d;
   logic          held_ext_q, held_ext_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          err_ovf_q, err_ovf_d;
   logic          err_kbd_q, err_kbd_d;
   logic          evt_valid_q, evt_valid_d;
   logic [7:0]    evt_code_q, evt_code_d;
   logic          evt_ext_q, evt_ext_d;
   logic          evt_brk_q, evt_brk_d;
   logic          evt_rpt_q, evt_rpt_d;
   logic [7:0]    evt_ascii_q, evt_ascii_d;
   logic [7:0]    lut_ascii;
   logic          held_match;

   ps2_scan2ascii u_scan2ascii (
      .scan_code (byte_q),
      .ascii     (lut_ascii)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         byte_q       <= 8'h00;
         nextdata_n_q <= 1'b1;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         held_q       <= 1'b0;
         held_code_q  <= 8'h00;
         held_ext_q   <= 1'b0;
         cnt_q        <= '0;
         err_ovf_q    <= 1'b0;
         err_kbd_q    <= 1'b0;
         evt_valid_q  <= 1'b0;
         evt_code_q   <= 8'h00;
         evt_ext_q    <= 1'b0;
         evt_brk_q    <= 1'b0;
         evt_rpt_q    <= 1'b0;
         evt_ascii_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         byte_q       <= byte_d;
         nextdata_n_q <= nextdata_n_d;
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
         held_q       <= held_d;
         held_code_q  <= held_code_d;
         held_ext_q   <= held_ext_d;
         cnt_q        <= cnt_d;
         err_ovf_q    <= err_ovf_d;
         err_kbd_q    <= err_kbd_d;
         evt_valid_q  <= evt_valid_d;
         evt_code_q   <= evt_code_d;
         evt_ext_q    <= evt_ext_d;
         evt_brk_q    <= evt_brk_d;
         evt_rpt_q    <= evt_rpt_d;
         evt_ascii_q  <= evt_ascii_d;
      end
   end

   // ACK exists only to give the FIFO one cycle to retire the popped byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (kbd_ready) state_d = ST_ACK;
         ST_ACK:   state_d = ST_PARSE;
         ST_PARSE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      logic carry;
      cnt_inc = cnt_q;
      carry   = 1'b1;
      for (int i = 0; i < CNT_DIGITS; i++) begin
         if (carry) begin
            if (cnt_q[4*i +: 4] == 4'd9) begin
               cnt_inc[4*i +: 4] = 4'd0;
            end else begin
               cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   assign held_match = held_q && (held_code_q == byte_q) && (held_ext_q == ext_pend_q);

   always_comb begin
      byte_d       = byte_q;
      nextdata_n_d = 1'b1;
      ext_pend_d   = ext_pend_q;
      brk_pend_d   = brk_pend_q;
      held_d       = held_q;
      held_code_d  = held_code_q;
      held_ext_d   = held_ext_q;
      cnt_d        = cnt_q;
      err_ovf_d    = err_ovf_q | kbd_overflow;
      err_kbd_d    = err_kbd_q;
      evt_valid_d  = 1'b0;
      evt_code_d   = evt_code_q;
      evt_ext_d    = evt_ext_q;
      evt_brk_d    = evt_brk_q;
      evt_rpt_d    = evt_rpt_q;
      evt_ascii_d  = evt_ascii_q;
      case (state_q)
         ST_IDLE: begin
            if (kbd_ready) begin
               byte_d       = kbd_data;
               nextdata_n_d = 1'b0;
            end
         end
         ST_PARSE: begin
            if (byte_q == SC_EXT) begin
               ext_pend_d = 1'b1;
            end else if (byte_q == SC_BRK) begin
               brk_pend_d = 1'b1;
            end else if (byte_q == SC_ERR0 || byte_q == SC_ERR1) begin
               err_kbd_d  = 1'b1;
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
            end else begin
               evt_valid_d = 1'b1;
               evt_code_d  = byte_q;
               evt_ext_d   = ext_pend_q;
               evt_brk_d   = brk_pend_q;
               evt_ascii_d = ext_pend_q ? ASCII_NONE : lut_ascii;
               evt_rpt_d   = 1'b0;
               if (!brk_pend_q) begin
                  if (held_match) begin
                     evt_rpt_d = 1'b1;
                  end else begin
                     held_d      = 1'b1;
                     held_code_d = byte_q;
                     held_ext_d  = ext_pend_q;
                     cnt_d       = cnt_inc;
                  end
               end else if (held_match) begin
                  held_d = 1'b0;
               end
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign kbd_nextdata_n = nextdata_n_q;
   assign evt_valid      = evt_valid_q;
   assign evt_code       = evt_code_q;
   assign evt_ext        = evt_ext_q;
   assign evt_break      = evt_brk_q;
   assign evt_repeat     = evt_rpt_q;
   assign evt_ascii      = evt_ascii_q;
   assign key_held       = held_q;
   assign held_code      = held_code_q;
   assign press_cnt      = cnt_q;
   assign err_overflow   = err_ovf_q;
   assign err_kbd        = err_kbd_q;

endmodule
